cmd_dispatch: RTL and testbench

Command dispatcher directly downstream of the UART command wrapper. Takes each assembled 16-bit command and acknowledges it via `clr_cmd_rdy`. Decodes the opcode and starts calibration, a move, or a tour. Waits for completion under a timeout, then returns a one-byte response through the wrapper's `resp`/`trmt`/`tx_done` transmit handshake.

---
 rtl/cmd_dispatch_pkg.sv | 29 ++
 rtl/cmd_dispatch_if.sv | 33 +++
 rtl/cmd_dispatch_timer.sv | 30 +++
 rtl/cmd_dispatch.sv | 117 +++++++++++
 tb/tb_cmd_dispatch.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cmd_dispatch_pkg.sv
// Shared types and constants for the command dispatcher.
// Holds the FSM state encoding, opcode values and response bytes.
// No logic beyond a small opcode classification helper.
package cmd_dispatch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    EXEC,
    CAL_WAIT,
    MOVE_WAIT,
    RESP,
    TX_WAIT
  } disp_state_t;

  localparam logic [3:0] OP_CAL     = 4'h2;
  localparam logic [3:0] OP_MOVE    = 4'h4;
  localparam logic [3:0] OP_MOVE_FF = 4'h5;
  localparam logic [3:0] OP_TOUR    = 4'h6;

  localparam logic [7:0] RESP_ACK  = 8'hA5;
  localparam logic [7:0] RESP_NACK = 8'hEE;
  localparam logic [7:0] RESP_TMO  = 8'hDD;

  // Both move flavours share the same datapath; only fanfare differs.
  function automatic logic is_move(input logic [3:0] op);
    return (op == OP_MOVE) || (op == OP_MOVE_FF);
  endfunction

endpackage

// File: rtl/cmd_dispatch_if.sv
// Bundle of every dispatcher-facing signal: UART command/response handshake
// plus the calibration, move and tour start/done lines.
// master = surrounding logic (wrapper, motion, tour); slave = the dispatcher.
interface cmd_dispatch_if;
  logic        cmd_rdy;
  logic [15:0] cmd;
  logic        clr_cmd_rdy;
  logic [7:0]  resp;
  logic        trmt;
  logic        tx_done;
  logic        strt_cal;
  logic        cal_done;
  logic        move_go;
  logic [7:0]  heading;
  logic [2:0]  squares;
  logic        move_done;
  logic        fanfare;
  logic        tour_go;
  logic [5:0]  tour_xy;
  logic        busy;

  modport master (
    output cmd_rdy, cmd, tx_done, cal_done, move_done,
    input  clr_cmd_rdy, resp, trmt, strt_cal, move_go, heading, squares,
           fanfare, tour_go, tour_xy, busy
  );

  modport slave (
    input  cmd_rdy, cmd, tx_done, cal_done, move_done,
    output clr_cmd_rdy, resp, trmt, strt_cal, move_go, heading, squares,
           fanfare, tour_go, tour_xy, busy
  );
endinterface

// File: rtl/cmd_dispatch_timer.sv
// Timeout counter for the calibration/move wait states.
// Latency: expired is a combinational compare of the registered count.
// Backpressure: none; clr has priority over en.
// Ports: clk, rst (sync, active-high), clr, en, expired.
module dispatch_timer #(
  parameter int unsigned     TO_W    = 24,
  parameter logic [TO_W-1:0] TIMEOUT = TO_W'(24'd10_000_000)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [TO_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= count_q + TO_W'(1);
    end
  end

  assign expired = (count_q == (TIMEOUT - TO_W'(1)));

endmodule

// File: rtl/cmd_dispatch.sv
// Decodes UART commands, launches calibrate/move/tour, returns a response byte.
// Latency: ack same cycle as cmd_rdy in IDLE, start pulse +1, trmt one cycle after done/decode.
// Backpressure: cmd_rdy held off (not acked) while busy; waits on tx_done before accepting more.
// Ports: clk, rst (sync, active-high), bus (cmd_dispatch_if.slave).
module cmd_dispatch
  import cmd_dispatch_pkg::*;
#(
  parameter int unsigned     TO_W    = 24,
  parameter logic [TO_W-1:0] TIMEOUT = TO_W'(24'd10_000_000)
) (
  input  logic           clk,
  input  logic           rst,
  cmd_dispatch_if.slave  bus
);

  disp_state_t state_q;
  logic [15:0] cmd_q;
  logic [7:0]  resp_q;
  logic [3:0]  op;
  logic        tmr_expired;
  logic        cmd_unused;

  assign op         = cmd_q[15:12];
  // Bit 3 carries no field for any opcode.
  assign cmd_unused = cmd_q[3];

  dispatch_timer #(
    .TO_W    (TO_W),
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (state_q == EXEC),
    .en      ((state_q == CAL_WAIT) || (state_q == MOVE_WAIT)),
    .expired (tmr_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      resp_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.cmd_rdy) begin
            cmd_q   <= bus.cmd;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          if (op == OP_CAL) begin
            state_q <= CAL_WAIT;
          end else if (is_move(op)) begin
            if (cmd_q[2:0] != 3'd0) begin
              state_q <= MOVE_WAIT;
            end else begin
              // Zero-length move: nothing to do, acknowledge immediately.
              resp_q  <= RESP_ACK;
              state_q <= RESP;
            end
          end else if (op == OP_TOUR) begin
            // Tour logic sends its own reply.
            state_q <= IDLE;
          end else begin
            resp_q  <= RESP_NACK;
            state_q <= RESP;
          end
        end
        CAL_WAIT: begin
          // Done is checked first so it wins a tie with expiry.
          if (bus.cal_done) begin
            resp_q  <= RESP_ACK;
            state_q <= RESP;
          end else if (tmr_expired) begin
            resp_q  <= RESP_TMO;
            state_q <= RESP;
          end
        end
        MOVE_WAIT: begin
          if (bus.move_done) begin
            resp_q  <= RESP_ACK;
            state_q <= RESP;
          end else if (tmr_expired) begin
            resp_q  <= RESP_TMO;
            state_q <= RESP;
          end
        end
        RESP: begin
          state_q <= TX_WAIT;
        end
        TX_WAIT: begin
          if (bus.tx_done) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Ack is gated by rst so a command presented during reset is not lost.
  assign bus.clr_cmd_rdy = (state_q == IDLE) && bus.cmd_rdy && !rst;
  assign bus.strt_cal    = (state_q == EXEC) && (op == OP_CAL);
  assign bus.move_go     = (state_q == EXEC) && is_move(op) && (cmd_q[2:0] != 3'd0);
  assign bus.tour_go     = (state_q == EXEC) && (op == OP_TOUR);
  assign bus.fanfare     = (state_q == MOVE_WAIT) && bus.move_done && (op == OP_MOVE_FF);
  assign bus.trmt        = (state_q == RESP);
  assign bus.busy        = (state_q != IDLE);
  assign bus.resp        = resp_q;
  assign bus.heading     = cmd_q[11:4];
  assign bus.squares     = cmd_q[2:0];
  assign bus.tour_xy     = {cmd_q[6:4], cmd_q[2:0]};

endmodule

// File: tb/tb_cmd_dispatch.sv
// Scoreboard bench for cmd_dispatch: directed cases then randomized commands.
// Driver predicts each output event (kind, data, cycle) from opcode rules.
// Monitor pops and compares whenever a pulse output fires.
module tb_cmd_dispatch;
  import cmd_dispatch_pkg::*;

  localparam int T = 16;
  localparam int EV_CAL  = 0;
  localparam int EV_MOVE = 1;
  localparam int EV_TOUR = 2;
  localparam int EV_FAN  = 3;
  localparam int EV_TX   = 4;

  typedef struct {
    int kind;
    int data;
    int cyc;
  } ev_t;

  ev_t  exp_q[$];
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  int   pending_exp = 0;

  cmd_dispatch_if bus();

  cmd_dispatch #(
    .TO_W    (24),
    .TIMEOUT (24'd16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic void push(input int k, input int d, input int c);
    ev_t e;
    e.kind = k;
    e.data = d;
    e.cyc  = c;
    exp_q.push_back(e);
  endfunction

  task automatic take(input int kind, input int data);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_total++;
      $display("FAIL unexpected_event: kind %0d data 0x%0h at cycle %0d, none expected", kind, data, cyc);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", kind, e.kind);
      check("event_data", data, e.data);
      check("event_cycle", cyc, e.cyc);
    end
  endtask

  // Monitor: samples 2 time units after the falling edge.
  always @(negedge clk) begin
    #2;
    if (bus.clr_cmd_rdy) check("ack_only_when_idle", int'(bus.busy), 0);
    if (bus.strt_cal)    take(EV_CAL, 0);
    if (bus.move_go)     take(EV_MOVE, int'({bus.heading, bus.squares}));
    if (bus.tour_go)     take(EV_TOUR, int'(bus.tour_xy));
    if (bus.fanfare)     take(EV_FAN, 0);
    if (bus.trmt)        take(EV_TX, int'(bus.resp));
  end

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Presents c (unless already pending) and waits for the acknowledge.
  task automatic raise_and_ack(input logic [15:0] c, output int n, output bit got);
    got = 1'b0;
    n   = -1;
    if (!bus.cmd_rdy) begin
      bus.cmd_rdy = 1'b1;
      bus.cmd     = c;
    end
    for (int k = 0; k < 64 && !got; k++) begin
      #1;
      if (bus.clr_cmd_rdy) got = 1'b1;
      else @(negedge clk);
    end
    if (got) n = cyc;
    else begin
      n_total++;
      $display("FAIL ack_timeout: cmd 0x%04h never acknowledged, expected within 64 cycles", c);
      bus.cmd_rdy = 1'b0;
    end
  endtask

  // One full command: predict events from opcode rules, drive done/tx_done.
  task automatic run_cmd(input logic [15:0] c, input int dly, input int txd,
                         input bit early, input logic [15:0] c_nxt);
    int n, exp_n, tc, dcyc;
    bit got;
    logic [3:0] op;
    logic [2:0] sq;
    op = c[15:12];
    sq = c[2:0];
    exp_n = bus.cmd_rdy ? pending_exp : cyc;
    raise_and_ack(c, n, got);
    if (!got) return;
    check("ack_cycle", n, exp_n);
    @(negedge clk);
    bus.cmd_rdy = 1'b0;
    tc = n + 2;
    if (op == 4'h2 || op == 4'h4 || op == 4'h5) begin
      if (op != 4'h2 && sq == 3'd0) begin
        push(EV_TX, int'(RESP_ACK), n + 2);
      end else begin
        if (op == 4'h2) push(EV_CAL, 0, n + 1);
        else push(EV_MOVE, int'({c[11:4], c[2:0]}), n + 1);
        // Wait states begin at n+2; the last cycle before expiry is n+1+T.
        dcyc = n + 1 + dly;
        if (dly <= T) begin
          wait_cyc(dcyc);
          if (op == 4'h5) push(EV_FAN, 0, dcyc);
          push(EV_TX, int'(RESP_ACK), dcyc + 1);
          if (op == 4'h2) bus.cal_done = 1'b1;
          else bus.move_done = 1'b1;
          @(negedge clk);
          bus.cal_done  = 1'b0;
          bus.move_done = 1'b0;
          tc = dcyc + 1;
        end else begin
          tc = n + T + 2;
          push(EV_TX, int'(RESP_TMO), tc);
        end
      end
    end else if (op == 4'h6) begin
      push(EV_TOUR, int'({c[6:4], c[2:0]}), n + 1);
      wait_cyc(n + 2);
      #1;
      check("busy_after_tour", int'(bus.busy), 0);
      return;
    end else begin
      push(EV_TX, int'(RESP_NACK), n + 2);
    end
    wait_cyc(tc + txd);
    bus.tx_done = 1'b1;
    if (early) begin
      bus.cmd_rdy = 1'b1;
      bus.cmd     = c_nxt;
      pending_exp = cyc + 1;
    end
    @(negedge clk);
    bus.tx_done = 1'b0;
    #1;
    check("idle_after_tx", int'(bus.busy), 0);
  endtask

  function automatic logic [15:0] rand_cmd();
    logic [15:0] c;
    c = 16'($urandom);
    case ($urandom_range(0, 5))
      0: c[15:12] = 4'h2;
      1: c[15:12] = 4'h4;
      2: c[15:12] = 4'h5;
      3: c[15:12] = 4'h6;
      default: ;
    endcase
    if ($urandom_range(0, 4) == 0) c[2:0] = 3'd0;
    return c;
  endfunction

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] cur, nxt;
    bit early, got;
    int n;
    bus.cmd_rdy   = 1'b0;
    bus.cmd       = 16'h0000;
    bus.tx_done   = 1'b0;
    bus.cal_done  = 1'b0;
    bus.move_done = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_resp", int'(bus.resp), 0);
    check("rst_heading", int'(bus.heading), 0);
    check("rst_squares", int'(bus.squares), 0);
    check("rst_tour_xy", int'(bus.tour_xy), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_pulses", int'({bus.clr_cmd_rdy, bus.strt_cal, bus.move_go, bus.tour_go,
                              bus.fanfare, bus.trmt}), 0);

    // Directed cases.
    run_cmd(16'h2000, 5, 2, 1'b0, 16'h0);
    run_cmd(16'h5A03, 3, 1, 1'b0, 16'h0);
    run_cmd(16'h4FF0, 1, 1, 1'b0, 16'h0);
    run_cmd(16'hF123, 1, 3, 1'b0, 16'h0);
    run_cmd(16'h4001, T + 5, 1, 1'b0, 16'h0);
    run_cmd(16'h4001, T, 1, 1'b0, 16'h0);
    run_cmd(16'h5003, T + 2, 1, 1'b0, 16'h0);
    run_cmd(16'h2000, T + 1, 2, 1'b0, 16'h0);
    run_cmd(16'h6035, 1, 1, 1'b0, 16'h0);
    run_cmd(16'h5A03, 4, 2, 1'b1, 16'h2000);
    run_cmd(16'h2000, 2, 1, 1'b0, 16'h0);

    // Randomized commands, occasionally queued while the previous one is in flight.
    cur = rand_cmd();
    for (int i = 0; i < 40; i++) begin
      nxt   = rand_cmd();
      early = ($urandom_range(0, 2) == 0);
      run_cmd(cur, $urandom_range(1, T + 4), $urandom_range(1, 3), early, nxt);
      cur = nxt;
    end

    // Reset while a move is outstanding; the late move_done must be ignored.
    raise_and_ack(16'h4001, n, got);
    if (got) begin
      push(EV_MOVE, 1, n + 1);
      @(negedge clk);
      bus.cmd_rdy = 1'b0;
      wait_cyc(n + 3);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("midrst_resp", int'(bus.resp), 0);
      check("midrst_heading", int'(bus.heading), 0);
      check("midrst_squares", int'(bus.squares), 0);
      check("midrst_busy", int'(bus.busy), 0);
      check("midrst_trmt", int'(bus.trmt), 0);
      @(negedge clk);
      bus.move_done = 1'b1;
      @(negedge clk);
      bus.move_done = 1'b0;
      repeat (3) begin
        @(negedge clk);
        #1;
        check("ignored_done_busy", int'(bus.busy), 0);
      end
    end

    repeat (T + 4) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
